// File: rtl/input_block_crossbar_pkg.sv
// noc_params: shared NoC types (flit format, labels, port ids) and the XY routing helper.
`default_nettype none

package noc_params;

   localparam int MESH_SIZE_X      = 5;
   localparam int MESH_SIZE_Y      = 5;
   localparam int PORT_COUNT       = 5;
   localparam int VC_COUNT         = 2;
   localparam int PORT_SIZE        = $clog2(PORT_COUNT);
   localparam int VC_SIZE          = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1;
   localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
   localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
   localparam int FLIT_DATA_SIZE   = 16;
   localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef enum logic [PORT_SIZE-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

   typedef struct packed {
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   typedef struct packed {
      flit_label_t               flit_label;
      logic [VC_SIZE-1:0]        vc_id;
      logic [FLIT_DATA_SIZE-1:0] data;
   } flit_t;

   // Dimension-ordered routing: resolve X completely before Y.
   function automatic port_t xy_route(input head_data_t h, input int x_cur, input int y_cur);
      port_t p;
      if (int'(h.x_dest) > x_cur)      p = EAST;
      else if (int'(h.x_dest) < x_cur) p = WEST;
      else if (int'(h.y_dest) > y_cur) p = SOUTH;
      else if (int'(h.y_dest) < y_cur) p = NORTH;
      else                             p = LOCAL;
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/input_block_crossbar_if.sv
// Link, allocator and crossbar-select signals of the input block; slave = router, master = environment.
`default_nettype none

interface input_block_crossbar_if #(
   parameter int PORT_NUM = 5,
   parameter int VC_NUM   = 2
) ();
   import noc_params::*;

   flit_t [PORT_NUM-1:0]                               data_i;
   logic  [PORT_NUM-1:0]                               valid_flit_i;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   on_off_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   vc_allocatable_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   error_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   va_request_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]    out_port_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   va_grant_i;
   logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]      va_vc_i;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   sa_request_o;
   logic  [PORT_NUM-1:0][VC_NUM-1:0]                   sa_grant_i;
   logic  [PORT_NUM-1:0][PORT_SIZE-1:0]                xbar_sel_i;
   flit_t [PORT_NUM-1:0]                               data_o;

   modport slave (
      input  data_i, valid_flit_i, va_grant_i, va_vc_i, sa_grant_i, xbar_sel_i,
      output on_off_o, vc_allocatable_o, error_o, va_request_o, out_port_o,
             sa_request_o, data_o
   );

   modport master (
      output data_i, valid_flit_i, va_grant_i, va_vc_i, sa_grant_i, xbar_sel_i,
      input  on_off_o, vc_allocatable_o, error_o, va_request_o, out_port_o,
             sa_request_o, data_o
   );

endinterface

`default_nettype wire

// File: rtl/input_block_crossbar_vc_buffer.sv
// vc_buffer: one virtual channel -- flit FIFO, IDLE/VA/ACTIVE state machine, route and downstream-VC latch.
// Optional protocol checking is compiled in with IB_ERROR_CHECK_EN.
`default_nettype none

module vc_buffer
   import noc_params::*;
#(
   parameter int BUFFER_SIZE = 8,
   parameter int X_CURRENT   = MESH_SIZE_X / 2,
   parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 write_i,
   input  flit_t                data_i,
   input  logic                 pop_i,
   input  logic                 va_grant_i,
   input  logic [VC_SIZE-1:0]   va_vc_i,
   output flit_t                head_o,
   output logic                 on_off_o,
   output logic                 vc_allocatable_o,
   output logic                 error_o,
   output logic                 va_request_o,
   output logic                 sa_request_o,
   output logic [PORT_SIZE-1:0] out_port_o
);

   localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
   localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

   typedef enum logic [1:0] {IDLE, VA, ACTIVE} vc_state_t;

   flit_t              mem_q [BUFFER_SIZE];
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   vc_state_t          state_q;
   port_t              out_port_q;
   logic [VC_SIZE-1:0] ds_vc_q;

   logic  empty, full, accept, push, pop;
   logic  front_valid, front_is_head, front_is_tail, drop_orphan;
   flit_t front;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count_q == '0);
   assign full   = (count_q == CNT_W'(BUFFER_SIZE));
   assign accept = write_i && !full;

   // An empty FIFO exposes the incoming flit so a head can leave IDLE on its write edge.
   assign front         = empty ? data_i : mem_q[rd_ptr_q];
   assign front_valid   = !empty || accept;
   assign front_is_head = (front.flit_label == HEAD) || (front.flit_label == HEADTAIL);
   assign front_is_tail = (front.flit_label == TAIL) || (front.flit_label == HEADTAIL);

   // A BODY/TAIL reaching the front of an IDLE VC can never be routed; discard it so the VC cannot wedge.
   assign drop_orphan = (state_q == IDLE) && front_valid && !front_is_head;

   assign sa_request_o     = (state_q == ACTIVE) && !empty;
   assign va_request_o     = (state_q == VA);
   assign vc_allocatable_o = (state_q == IDLE) && empty;
   assign on_off_o         = (count_q < CNT_W'(BUFFER_SIZE - 1));
   assign out_port_o       = out_port_q;

   assign pop  = (pop_i && sa_request_o) || (drop_orphan && !empty);
   assign push = accept && !(drop_orphan && empty);

   always_comb begin
      head_o       = mem_q[rd_ptr_q];
      head_o.vc_id = ds_vc_q;
   end

   always_comb begin
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         out_port_q <= LOCAL;
         ds_vc_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (front_valid && front_is_head) begin
                  state_q    <= VA;
                  out_port_q <= xy_route(head_data_t'(front.data), X_CURRENT, Y_CURRENT);
               end
            end
            VA: begin
               if (va_grant_i) begin
                  state_q <= ACTIVE;
                  ds_vc_q <= va_vc_i;
               end
            end
            ACTIVE: begin
               if (pop && front_is_tail) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef IB_ERROR_CHECK_EN
   logic error_q, open_q, in_is_head;

   assign in_is_head = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);

   // A head is legal only with no open packet, a body/tail only inside one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         error_q <= 1'b0;
         open_q  <= 1'b0;
      end else if (write_i) begin
         if (full || (in_is_head == open_q)) error_q <= 1'b1;
         if (!full) open_q <= in_is_head ? (data_i.flit_label == HEAD)
                                         : (open_q && (data_i.flit_label == BODY));
      end
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/input_block_crossbar.sv
// input_block_crossbar: per-port VC input buffers, XY route computation, output registers and crossbar.
// Define IB_ERROR_CHECK_EN to enable sticky per-VC protocol error detection.
`default_nettype none

module input_block_crossbar
   import noc_params::*;
#(
   parameter int PORT_NUM    = PORT_COUNT,
   parameter int VC_NUM      = VC_COUNT,
   parameter int BUFFER_SIZE = 8,
   parameter int X_CURRENT   = MESH_SIZE_X / 2,
   parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
   input logic                  clk,
   input logic                  rst,
   input_block_crossbar_if.slave ib
);

   flit_t [PORT_NUM-1:0][VC_NUM-1:0] head;
   logic  [PORT_NUM-1:0][VC_NUM-1:0] sa_req;
   flit_t [PORT_NUM-1:0]             out_q;

   for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
      for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
         vc_buffer #(
            .BUFFER_SIZE (BUFFER_SIZE),
            .X_CURRENT   (X_CURRENT),
            .Y_CURRENT   (Y_CURRENT)
         ) u_vc (
            .clk              (clk),
            .rst              (rst),
            .write_i          (ib.valid_flit_i[p] && (ib.data_i[p].vc_id == VC_SIZE'(v))),
            .data_i           (ib.data_i[p]),
            .pop_i            (ib.sa_grant_i[p][v]),
            .va_grant_i       (ib.va_grant_i[p][v]),
            .va_vc_i          (ib.va_vc_i[p][v]),
            .head_o           (head[p][v]),
            .on_off_o         (ib.on_off_o[p][v]),
            .vc_allocatable_o (ib.vc_allocatable_o[p][v]),
            .error_o          (ib.error_o[p][v]),
            .va_request_o     (ib.va_request_o[p][v]),
            .sa_request_o     (sa_req[p][v]),
            .out_port_o       (ib.out_port_o[p][v])
         );
      end
   end

   assign ib.sa_request_o = sa_req;

   // Each input port owns one output register; it holds the last flit popped from that port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q <= '0;
      end else begin
         for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               if (ib.sa_grant_i[p][v] && sa_req[p][v]) out_q[p] <= head[p][v];
            end
         end
      end
   end

   always_comb begin
      ib.data_o = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         if (int'(ib.xbar_sel_i[o]) < PORT_NUM) ib.data_o[o] = out_q[ib.xbar_sel_i[o]];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_input_block_crossbar.sv
// Directed self-checking bench for input_block_crossbar; expected flits and ports are hand-derived.
`default_nettype none

module tb_input_block_crossbar;
   import noc_params::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_err;

   input_block_crossbar_if #(.PORT_NUM(5), .VC_NUM(2)) ib ();

   input_block_crossbar #(
      .PORT_NUM(5), .VC_NUM(2), .BUFFER_SIZE(8), .X_CURRENT(2), .Y_CURRENT(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ib  (ib)
   );

   always #5 clk = ~clk;

   function automatic flit_t mkf(input flit_label_t l, input logic [VC_SIZE-1:0] vc, input logic [15:0] d);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = vc;
      f.data       = d;
      return f;
   endfunction

   function automatic logic [15:0] hd(input int x, input int y, input int pl);
      return {3'(x), 3'(y), 10'(pl)};
   endfunction

   task automatic clear_inputs();
      ib.data_i       = '0;
      ib.valid_flit_i = '0;
      ib.va_grant_i   = '0;
      ib.va_vc_i      = '0;
      ib.sa_grant_i   = '0;
      ib.xbar_sel_i   = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      n_tests++; if (ib.on_off_o !== '1) begin n_fail++; $display("FAIL rst_on_off: got %h want all 1", ib.on_off_o); end
      n_tests++; if (ib.vc_allocatable_o !== '1) begin n_fail++; $display("FAIL rst_vc_alloc: got %h want all 1", ib.vc_allocatable_o); end
      n_tests++; if (ib.error_o !== '0) begin n_fail++; $display("FAIL rst_error: got %h want 0", ib.error_o); end
      n_tests++; if (ib.va_request_o !== '0) begin n_fail++; $display("FAIL rst_va_req: got %h want 0", ib.va_request_o); end
      n_tests++; if (ib.sa_request_o !== '0) begin n_fail++; $display("FAIL rst_sa_req: got %h want 0", ib.sa_request_o); end
      n_tests++; if (ib.data_o !== '0) begin n_fail++; $display("FAIL rst_data_o: got %h want 0", ib.data_o); end
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (ib.on_off_o !== '1 || ib.vc_allocatable_o !== '1) begin
         n_fail++; $display("FAIL rst_release: on_off %h alloc %h want all 1", ib.on_off_o, ib.vc_allocatable_o);
      end
   endtask

   task automatic test_packet();
      flit_t pkt [4];
      flit_t exp;
      pkt[0] = mkf(HEAD, 1'b0, hd(2, 2, 10'h2A));
      pkt[1] = mkf(BODY, 1'b0, 16'h1111);
      pkt[2] = mkf(BODY, 1'b0, 16'h2222);
      pkt[3] = mkf(TAIL, 1'b0, 16'h3333);
      ib.valid_flit_i[1] = 1'b1;
      ib.data_i[1]       = pkt[0];
      @(negedge clk);
      n_tests++; if (ib.va_request_o[1][0] !== 1'b1) begin n_fail++; $display("FAIL pkt_va_req: got %b want 1", ib.va_request_o[1][0]); end
      n_tests++; if (ib.out_port_o[1][0] !== LOCAL) begin n_fail++; $display("FAIL pkt_route: got %0d want %0d", ib.out_port_o[1][0], LOCAL); end
      for (int i = 1; i < 4; i++) begin
         ib.data_i[1] = pkt[i];
         @(negedge clk);
      end
      ib.valid_flit_i[1] = 1'b0;
      ib.va_grant_i[1][0] = 1'b1;
      ib.va_vc_i[1][0]    = 1'b1;
      @(negedge clk);
      ib.va_grant_i[1][0] = 1'b0;
      n_tests++; if (ib.va_request_o[1][0] !== 1'b0) begin n_fail++; $display("FAIL pkt_va_drop: got %b want 0", ib.va_request_o[1][0]); end
      n_tests++; if (ib.sa_request_o[1][0] !== 1'b1) begin n_fail++; $display("FAIL pkt_sa_req: got %b want 1", ib.sa_request_o[1][0]); end
      ib.xbar_sel_i[0]    = 3'd1;
      ib.sa_grant_i[1][0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp = pkt[i];
         exp.vc_id = 1'b1;
         n_tests++; if (ib.data_o[0] !== exp) begin n_fail++; $display("FAIL pkt_flit%0d: got %h want %h", i, ib.data_o[0], exp); end
      end
      ib.sa_grant_i[1][0] = 1'b0;
      n_tests++; if (ib.vc_allocatable_o[1][0] !== 1'b1 || ib.sa_request_o[1][0] !== 1'b0) begin
         n_fail++; $display("FAIL pkt_idle: alloc %b sa_req %b want 1/0", ib.vc_allocatable_o[1][0], ib.sa_request_o[1][0]);
      end
   endtask

   task automatic test_routing();
      int    xs [4];
      int    ys [4];
      port_t exp_port [4];
      xs = '{4, 0, 2, 2};
      ys = '{2, 2, 4, 0};
      exp_port = '{EAST, WEST, SOUTH, NORTH};
      for (int p = 1; p < 5; p++) begin
         ib.valid_flit_i[p] = 1'b1;
         ib.data_i[p]       = mkf(HEADTAIL, 1'b1, hd(xs[p-1], ys[p-1], p));
      end
      @(negedge clk);
      ib.valid_flit_i = '0;
      for (int p = 1; p < 5; p++) begin
         n_tests++; if (ib.out_port_o[p][1] !== exp_port[p-1]) begin
            n_fail++; $display("FAIL route_p%0d: got %0d want %0d", p, ib.out_port_o[p][1], exp_port[p-1]);
         end
         n_tests++; if (ib.va_request_o[p][1] !== 1'b1) begin n_fail++; $display("FAIL route_va_p%0d: got %b want 1", p, ib.va_request_o[p][1]); end
      end
   endtask

   task automatic test_backpressure();
      flit_t sent [9];
      sent[0] = mkf(HEAD, 1'b0, hd(2, 2, 7));
      for (int i = 1; i < 9; i++) sent[i] = mkf(BODY, 1'b0, 16'hB000 + 16'(i));
      ib.valid_flit_i[2] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ib.data_i[2] = sent[i];
         @(negedge clk);
         if (i == 5) begin
            n_tests++; if (ib.on_off_o[2][0] !== 1'b1) begin n_fail++; $display("FAIL bp_6writes: got %b want 1", ib.on_off_o[2][0]); end
         end
         if (i == 6 || i == 7) begin
            n_tests++; if (ib.on_off_o[2][0] !== 1'b0) begin n_fail++; $display("FAIL bp_%0dwrites: got %b want 0", i + 1, ib.on_off_o[2][0]); end
         end
      end
      ib.valid_flit_i[2] = 1'b0;
      n_tests++; if (ib.error_o[2][0] !== exp_err) begin n_fail++; $display("FAIL bp_full_err: got %b want %b", ib.error_o[2][0], exp_err); end
      ib.va_grant_i[2][0] = 1'b1;
      ib.va_vc_i[2][0]    = 1'b0;
      @(negedge clk);
      ib.va_grant_i[2][0] = 1'b0;
      ib.xbar_sel_i[0]    = 3'd2;
      ib.sa_grant_i[2][0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_tests++; if (ib.data_o[0] !== sent[i]) begin n_fail++; $display("FAIL bp_drain%0d: got %h want %h", i, ib.data_o[0], sent[i]); end
      end
      ib.sa_grant_i[2][0] = 1'b0;
      n_tests++; if (ib.sa_request_o[2][0] !== 1'b0) begin n_fail++; $display("FAIL bp_dropped9: sa_req %b want 0", ib.sa_request_o[2][0]); end
      n_tests++; if (ib.on_off_o[2][0] !== 1'b1) begin n_fail++; $display("FAIL bp_on_again: got %b want 1", ib.on_off_o[2][0]); end
      n_tests++; if (ib.error_o[2][0] !== exp_err) begin n_fail++; $display("FAIL bp_err_sticky: got %b want %b", ib.error_o[2][0], exp_err); end
   endtask

   task automatic test_error();
      ib.valid_flit_i[3] = 1'b1;
      ib.data_i[3]       = mkf(BODY, 1'b1, 16'h0BAD);
      ib.valid_flit_i[4] = 1'b1;
      ib.data_i[4]       = mkf(HEAD, 1'b0, hd(2, 2, 1));
      @(negedge clk);
      ib.valid_flit_i[3] = 1'b0;
      n_tests++; if (ib.error_o[3][1] !== exp_err) begin n_fail++; $display("FAIL err_orphan_body: got %b want %b", ib.error_o[3][1], exp_err); end
      n_tests++; if (ib.error_o[3][0] !== 1'b0) begin n_fail++; $display("FAIL err_neighbour: got %b want 0", ib.error_o[3][0]); end
      n_tests++; if (ib.error_o[4][0] !== 1'b0) begin n_fail++; $display("FAIL err_first_head: got %b want 0", ib.error_o[4][0]); end
      ib.data_i[4] = mkf(HEAD, 1'b0, hd(2, 2, 2));
      @(negedge clk);
      ib.valid_flit_i[4] = 1'b0;
      n_tests++; if (ib.error_o[4][0] !== exp_err) begin n_fail++; $display("FAIL err_head_open: got %b want %b", ib.error_o[4][0], exp_err); end
   endtask

   task automatic test_concurrency();
      flit_t a [2];
      flit_t b [2];
      flit_t ea, eb;
      a[0] = mkf(HEAD, 1'b0, hd(4, 2, 10'h155));
      a[1] = mkf(TAIL, 1'b0, 16'hA5A5);
      b[0] = mkf(HEAD, 1'b0, hd(2, 0, 10'h0AA));
      b[1] = mkf(TAIL, 1'b0, 16'h5A5A);
      ib.valid_flit_i[1] = 1'b1;
      ib.valid_flit_i[3] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ib.data_i[1] = a[i];
         ib.data_i[3] = b[i];
         @(negedge clk);
      end
      ib.valid_flit_i = '0;
      n_tests++; if (ib.out_port_o[1][0] !== EAST) begin n_fail++; $display("FAIL cc_route1: got %0d want %0d", ib.out_port_o[1][0], EAST); end
      n_tests++; if (ib.out_port_o[3][0] !== NORTH) begin n_fail++; $display("FAIL cc_route3: got %0d want %0d", ib.out_port_o[3][0], NORTH); end
      ib.va_grant_i[1][0] = 1'b1;
      ib.va_grant_i[3][0] = 1'b1;
      ib.va_vc_i[1][0]    = 1'b0;
      ib.va_vc_i[3][0]    = 1'b1;
      @(negedge clk);
      ib.va_grant_i    = '0;
      ib.xbar_sel_i[4] = 3'd1;
      ib.xbar_sel_i[1] = 3'd3;
      ib.sa_grant_i[1][0] = 1'b1;
      ib.sa_grant_i[3][0] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         ea = a[i];
         eb = b[i];
         eb.vc_id = 1'b1;
         n_tests++; if (ib.data_o[4] !== ea) begin n_fail++; $display("FAIL cc_east%0d: got %h want %h", i, ib.data_o[4], ea); end
         n_tests++; if (ib.data_o[1] !== eb) begin n_fail++; $display("FAIL cc_north%0d: got %h want %h", i, ib.data_o[1], eb); end
      end
      ib.sa_grant_i = '0;
      n_tests++; if (ib.vc_allocatable_o[1][0] !== 1'b1 || ib.vc_allocatable_o[3][0] !== 1'b1) begin
         n_fail++; $display("FAIL cc_idle: alloc1 %b alloc3 %b want 1/1", ib.vc_allocatable_o[1][0], ib.vc_allocatable_o[3][0]);
      end
   endtask

   initial begin
`ifdef IB_ERROR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      clear_inputs();
      test_reset();
      test_packet();
      test_routing();
      test_reset();
      test_backpressure();
      test_reset();
      test_error();
      test_reset();
      test_concurrency();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
